// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
package ram_arbiter_pkg;

  // Arbiter control states: normal arbitration, or the write half of a
  // read-modify-write.
  typedef enum logic {
    ARB = 1'b0,
    RMW = 1'b1
  } state_t;

  // Requester identities, also used as bit indices into request/grant vectors.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int BYTE_W = 8;

  // Pick one byte of a merged word: the new byte when its enable is set,
  // otherwise the byte already stored in RAM.
  function automatic logic [BYTE_W-1:0] mergeByte(
    input logic [BYTE_W-1:0] oldByte,
    input logic [BYTE_W-1:0] newByte,
    input logic              take
  );
    return take ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the port that wins a tie and
// is moved to the other port whenever a grant is issued.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  port_t r_prio;

  // Combinational grant: lone requester wins, a tie goes to the pointer.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[PORT_A] && i_req[PORT_B]) begin
        o_gnt[r_prio] = 1'b1;
      end else if (i_req[PORT_A]) begin
        o_gnt[PORT_A] = 1'b1;
      end else if (i_req[PORT_B]) begin
        o_gnt[PORT_B] = 1'b1;
      end
    end
  end

  // Pointer points away from whichever port was just granted; A wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= PORT_A;
    end else if (o_gnt[PORT_A]) begin
      r_prio <= PORT_B;
    end else if (o_gnt[PORT_B]) begin
      r_prio <= PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a read-only fetch port (A) and a load/store port (B) onto one
// single-port synchronous write-first RAM. Partial-byte stores are done as a
// read in the grant cycle followed by a merged write in an RMW cycle.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter  int DEPTH      = 2**16,
  parameter  int DATA_WIDTH = 32,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_req,
  input  logic [AW-1:0]         i_a_addr,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [BW-1:0]         i_b_be,
  input  logic [AW-1:0]         i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic [AW-1:0]         o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  state_t                r_state;
  state_t                w_nextState;
  logic [AW-1:0]         r_rmwAddr;
  logic [BW-1:0]         r_rmwBe;
  logic [DATA_WIDTH-1:0] r_rmwData;
  logic                  r_aValid;
  logic                  r_bValid;
  logic [DATA_WIDTH-1:0] r_aHold;
  logic [DATA_WIDTH-1:0] r_bHold;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_arbEn;
  logic                  w_bFull;
  logic                  w_bPartial;
  logic                  w_startRmw;
  logic [DATA_WIDTH-1:0] w_merged;

  // Grants are only possible while arbitrating and out of reset, so nothing
  // is accepted during reset or during the RMW write cycle.
  assign w_req      = {i_b_req, i_a_req};
  assign w_arbEn    = (r_state == ARB) && i_rst_n;
  assign o_a_gnt    = w_gnt[PORT_A];
  assign o_b_gnt    = w_gnt[PORT_B];
  assign w_bFull    = &i_b_be;
  assign w_bPartial = (|i_b_be) && !w_bFull;
  assign w_startRmw = w_gnt[PORT_B] && i_b_we && w_bPartial;

  rr_arb2 u_rrArb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_arbEn),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  // Merge the latched store bytes over the word read back in the grant cycle.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < BW; i++) begin
      w_merged[i*BYTE_W +: BYTE_W] = mergeByte(i_ram_data[i*BYTE_W +: BYTE_W],
                                               r_rmwData[i*BYTE_W +: BYTE_W],
                                               r_rmwBe[i]);
    end
  end

  // Next state and RAM-side drive; reads, full writes and empty-mask writes
  // stay in ARB, partial writes take one extra cycle in RMW.
  always_comb begin
    w_nextState = r_state;
    o_ram_we    = 1'b0;
    o_ram_addr  = i_a_addr;
    o_ram_data  = i_b_wdata;
    case (r_state)
      ARB: begin
        if (w_gnt[PORT_B]) begin
          o_ram_addr = i_b_addr;
          if (i_b_we && w_bFull) begin
            o_ram_we = 1'b1;
          end else if (w_startRmw) begin
            w_nextState = RMW;
          end
        end
      end
      RMW: begin
        o_ram_we    = 1'b1;
        o_ram_addr  = r_rmwAddr;
        o_ram_data  = w_merged;
        w_nextState = ARB;
      end
      default: begin
        w_nextState = ARB;
      end
    endcase
  end

  // State register; reset drops straight back to ARB, aborting any RMW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the partial store so the merge can happen next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rmwAddr <= '0;
      r_rmwBe   <= '0;
      r_rmwData <= '0;
    end else if (w_startRmw) begin
      r_rmwAddr <= i_b_addr;
      r_rmwBe   <= i_b_be;
      r_rmwData <= i_b_wdata;
    end
  end

  // Read return: valid one cycle after the grant, data held afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aValid <= 1'b0;
      r_bValid <= 1'b0;
      r_aHold  <= '0;
      r_bHold  <= '0;
    end else begin
      r_aValid <= w_gnt[PORT_A];
      r_bValid <= w_gnt[PORT_B] && !i_b_we;
      if (r_aValid) begin
        r_aHold <= i_ram_data;
      end
      if (r_bValid) begin
        r_bHold <= i_ram_data;
      end
    end
  end

  assign o_a_rvalid = r_aValid;
  assign o_b_rvalid = r_bValid;
  assign o_a_rdata  = r_aValid ? i_ram_data : r_aHold;
  assign o_b_rdata  = r_bValid ? i_ram_data : r_bHold;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a write-first RAM, a transaction-level model checked
// every falling edge, directed scenarios with literal expectations, then
// randomized traffic with occasional resets.
module tb_ram_arbiter;

  localparam int DEPTH = 256;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0;
  logic          b_we = 1'b0;
  logic [BW-1:0] b_be = '0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int total = 0;
  int bad   = 0;

  // Values seen at the falling edge of the last applyStimulus cycle.
  logic          sawAGnt, sawBGnt, sawWe;
  logic [DW-1:0] sawRamData;
  logic [AW-1:0] sawRamAddr;

  // Transaction-level model state.
  logic [DW-1:0] model [DEPTH];
  logic          mBusy = 1'b0;
  logic          mFavB = 1'b0;
  logic          mPendA = 1'b0, mPendB = 1'b0;
  logic [DW-1:0] mDataA = '0, mDataB = '0, mHoldA = '0, mHoldB = '0;
  logic [AW-1:0] mRmwAddr = '0;
  logic [BW-1:0] mRmwBe = '0;
  logic [DW-1:0] mRmwData = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_a_req    (a_req),
    .i_a_addr   (a_addr),
    .o_a_gnt    (a_gnt),
    .o_a_rvalid (a_rvalid),
    .o_a_rdata  (a_rdata),
    .i_b_req    (b_req),
    .i_b_we     (b_we),
    .i_b_be     (b_be),
    .i_b_addr   (b_addr),
    .i_b_wdata  (b_wdata),
    .o_b_gnt    (b_gnt),
    .o_b_rvalid (b_rvalid),
    .o_b_rdata  (b_rdata),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_wdata),
    .o_ram_we   (ram_we),
    .i_ram_data (ram_q)
  );

  // Single-port synchronous write-first RAM, one cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      ram_q         <= ram_wdata;
    end else begin
      ram_q <= ram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model as
  // if the coming rising edge commits the cycle's transaction.
  task automatic checkOutput();
    logic          ga, gb, nPendA, nPendB;
    logic [DW-1:0] nDataA, nDataB, w;
    if (!rst_n) begin
      check("rstAGnt", a_gnt, 0);
      check("rstBGnt", b_gnt, 0);
      check("rstARvalid", a_rvalid, 0);
      check("rstBRvalid", b_rvalid, 0);
      check("rstARdata", a_rdata, 0);
      check("rstBRdata", b_rdata, 0);
      check("rstWe", ram_we, 0);
      mBusy = 0; mFavB = 0; mPendA = 0; mPendB = 0;
      mHoldA = '0; mHoldB = '0;
    end else begin
      check("aRvalid", a_rvalid, mPendA);
      if (mPendA) begin
        check("aRdata", a_rdata, mDataA);
        mHoldA = mDataA;
      end else begin
        check("aRdataHold", a_rdata, mHoldA);
      end
      check("bRvalid", b_rvalid, mPendB);
      if (mPendB) begin
        check("bRdata", b_rdata, mDataB);
        mHoldB = mDataB;
      end else begin
        check("bRdataHold", b_rdata, mHoldB);
      end
      ga = 0; gb = 0; nPendA = 0; nPendB = 0; nDataA = '0; nDataB = '0;
      if (!mBusy) begin
        if (a_req && b_req) begin
          ga = !mFavB;
          gb = mFavB;
        end else begin
          ga = a_req;
          gb = b_req;
        end
      end
      check("aGnt", a_gnt, ga);
      check("bGnt", b_gnt, gb);
      if (mBusy) begin
        w = model[mRmwAddr];
        for (int i = 0; i < BW; i++) if (mRmwBe[i]) w[i*8 +: 8] = mRmwData[i*8 +: 8];
        check("rmwWe", ram_we, 1);
        check("rmwAddr", ram_addr, mRmwAddr);
        check("rmwData", ram_wdata, w);
        model[mRmwAddr] = w;
        mBusy = 0;
      end else if (ga) begin
        check("aReadWe", ram_we, 0);
        check("aReadAddr", ram_addr, a_addr);
        nPendA = 1; nDataA = model[a_addr];
        mFavB = 1;
      end else if (gb) begin
        mFavB = 0;
        check("bAddr", ram_addr, b_addr);
        if (!b_we) begin
          check("bReadWe", ram_we, 0);
          nPendB = 1; nDataB = model[b_addr];
        end else if (b_be == '1) begin
          check("bFullWe", ram_we, 1);
          check("bFullData", ram_wdata, b_wdata);
          model[b_addr] = b_wdata;
        end else if (b_be != '0) begin
          check("bPartWe", ram_we, 0);
          mBusy = 1; mRmwAddr = b_addr; mRmwBe = b_be; mRmwData = b_wdata;
        end else begin
          check("bNoopWe", ram_we, 0);
        end
      end else begin
        check("idleWe", ram_we, 0);
      end
      mPendA = nPendA; mDataA = nDataA;
      mPendB = nPendB; mDataB = nDataB;
    end
  endtask

  always @(negedge clk) checkOutput();

  // Drive one cycle of requests, record what the DUT did mid-cycle, and
  // return just after the next rising edge.
  task automatic applyStimulus(input logic aReq, input logic [AW-1:0] aAddr,
                               input logic bReq, input logic bWe, input logic [BW-1:0] bBe,
                               input logic [AW-1:0] bAddr, input logic [DW-1:0] bWdata);
    a_req = aReq; a_addr = aAddr;
    b_req = bReq; b_we = bWe; b_be = bBe; b_addr = bAddr; b_wdata = bWdata;
    @(negedge clk);
    sawAGnt = a_gnt; sawBGnt = b_gnt; sawWe = ram_we;
    sawRamData = ram_wdata; sawRamAddr = ram_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, '0, 0, 0, '0, '0, '0);
  endtask

  logic [AW-1:0] aNext;
  logic          rA, rB, rBWe;
  logic [AW-1:0] rAAddr, rBAddr;
  logic [BW-1:0] rBBe;
  logic [DW-1:0] rBData, pre;

  initial begin
    // Requests active during reset must not be granted.
    a_req = 1; b_req = 1; b_we = 1; b_be = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("litRstGnt", {a_gnt, b_gnt, ram_we}, 3'b000);
    rst_n = 1;

    // Preload every address the test touches with a full B write.
    for (int i = 0; i < 96; i++) begin
      if (i == 8'h10)      pre = 32'hDEADBEEF;
      else if (i == 8'h30) pre = 32'hAABBCCDD;
      else if (i == 8'h40) pre = 32'h00000055;
      else                 pre = 32'hC0DE0000 | DW'(i);
      applyStimulus(0, '0, 1, 1, 4'hF, AW'(i), pre);
    end
    idle();

    // Both ports reading every cycle: grants alternate starting with A.
    aNext = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, aNext, 1, 0, '0, 8'h10, '0);
      check("litAltGnt", sawAGnt, (i % 2) == 0);
      if (sawAGnt) begin
        check("litAltARv", a_rvalid, 1);
        check("litAltAData", a_rdata, 32'hC0DE0000 | DW'(aNext));
        check("litAltBRv", b_rvalid, 0);
        aNext = aNext + 1'b1;
      end else begin
        check("litAltBRv", b_rvalid, 1);
        check("litAltBData", b_rdata, 32'hDEADBEEF);
      end
    end

    // Full write followed immediately by a read of the same word.
    applyStimulus(0, '0, 1, 1, 4'hF, 8'h20, 32'h12345678);
    check("litFullWe", sawWe, 1);
    applyStimulus(1, 8'h20, 0, 0, '0, '0, '0);
    check("litRawGnt", sawAGnt, 1);
    check("litRawData", a_rdata, 32'h12345678);

    // Partial write with A contending: B wins, A waits through RMW.
    applyStimulus(1, 8'h50, 1, 1, 4'b0101, 8'h30, 32'h11223344);
    check("litRmwBGnt", sawBGnt, 1);
    check("litRmwAGnt0", sawAGnt, 0);
    applyStimulus(1, 8'h50, 0, 0, '0, '0, '0);
    check("litRmwAGnt1", sawAGnt, 0);
    check("litRmwWe", sawWe, 1);
    check("litRmwAddr", sawRamAddr, 8'h30);
    check("litRmwData", sawRamData, 32'hAA22CC44);
    applyStimulus(1, 8'h50, 0, 0, '0, '0, '0);
    check("litRmwAGnt2", sawAGnt, 1);
    applyStimulus(1, 8'h30, 0, 0, '0, '0, '0);
    check("litRmwRead", a_rdata, 32'hAA22CC44);

    // Empty byte mask: accepted but nothing written.
    applyStimulus(0, '0, 1, 1, 4'b0000, 8'h40, 32'hFFFFFFFF);
    check("litNoopGnt", sawBGnt, 1);
    check("litNoopWe", sawWe, 0);
    applyStimulus(1, 8'h40, 0, 0, '0, '0, '0);
    check("litNoopData", a_rdata, 32'h00000055);

    // Reset during RMW: no write, word unchanged, A wins the first tie.
    applyStimulus(0, '0, 1, 1, 4'b0011, 8'h30, 32'h99887766);
    a_req = 1; a_addr = 8'h30; b_req = 1; b_we = 0; b_addr = 8'h10;
    rst_n = 0;
    #1;
    check("litRstRmwWe", ram_we, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    applyStimulus(1, 8'h30, 1, 0, '0, 8'h10, '0);
    check("litRstTieA", sawAGnt, 1);
    check("litRstKeep", a_rdata, 32'hAA22CC44);

    // Reset after an A grant also returns the tie to A.
    applyStimulus(1, 8'h01, 0, 0, '0, '0, '0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    applyStimulus(1, 8'h02, 1, 0, '0, 8'h03, '0);
    check("litRst2TieA", sawAGnt, 1);

    // Random traffic; each requester holds its request until granted.
    rA = 0; rB = 0; rAAddr = '0; rBAddr = '0; rBWe = 0; rBBe = '0; rBData = '0;
    sawAGnt = 0; sawBGnt = 0;
    for (int n = 0; n < 800; n++) begin
      if (!rA || sawAGnt) begin
        rA = ($urandom_range(0, 9) < 7);
        rAAddr = AW'($urandom_range(0, 95));
      end
      if (!rB || sawBGnt) begin
        rB = ($urandom_range(0, 9) < 7);
        rBAddr = AW'($urandom_range(0, 95));
        rBWe = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0: rBBe = 4'h0;
          1: rBBe = 4'hF;
          default: rBBe = BW'($urandom_range(0, 15));
        endcase
        rBData = $urandom;
      end
      if ($urandom_range(0, 99) == 0) rst_n = 0;
      applyStimulus(rA, rAAddr, rB, rBWe, rBBe, rBAddr, rBData);
      if (!rst_n) begin
        sawAGnt = 0; sawBGnt = 0;
        rst_n = 1;
      end
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
